// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and helpers for the async FIFO read/write schedulers.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Widest requester vector the index helper accepts.
    localparam int C_MAX_REQ = 32;
    localparam int C_IDX_W   = 5;

    function automatic logic [C_IDX_W-1:0] onehot_to_idx(input logic [C_MAX_REQ-1:0] i_oh);
        logic [C_IDX_W-1:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < C_MAX_REQ; i++) begin
            if (i_oh[i]) begin
                w_idx = C_IDX_W'(i);
            end
        end
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter; first request at or above the
//            pointer wins, searching upward with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap keeps non-power-of-2 NREQ in range.
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req[PW'(w_idx)]) begin
                o_gnt[PW'(w_idx)] = 1'b1;
                w_found           = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_sched
// Purpose  : Read-side burst scheduler for the async FIFO with round-robin
//            consumer arbitration and a 2-entry skid buffer on read data.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_sched
    import fifo_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic            rclk,
    input  logic            rrst_n,
    input  logic [NREQ-1:0] req,
    input  logic            rempty,
    output logic            rinc,
    input  logic [DW-1:0]   rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [NREQ-1:0] out_gnt,
    output logic            burst_done
);

    localparam int C_PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int C_IW = $clog2(BURST + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_PW-1:0]   r_rr_ptr;
    logic [C_PW-1:0]   r_winner;
    logic [NREQ-1:0]   r_gnt;
    logic [C_IW-1:0]   r_issued;
    logic              r_inflight;
    logic              r_burst_done;
    logic [1:0]        r_occ;
    logic [DW-1:0]     r_e0;
    logic [DW-1:0]     r_e1;

    logic [NREQ-1:0]   w_arb_gnt;
    logic [C_PW-1:0]   w_arb_idx;
    logic              w_rinc;
    logic              w_start;
    logic              w_exit;
    logic              w_req_win;
    logic              w_below_burst;
    logic              w_credit_ok;
    logic              w_push;
    logic              w_pop;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (C_PW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_arb_gnt)
    );

    assign w_arb_idx     = C_PW'(onehot_to_idx(C_MAX_REQ'(w_arb_gnt)));
    assign w_req_win     = req[r_winner];
    assign w_below_burst = (r_issued < C_IW'(BURST));
    // Credit: skid entries plus the word in flight may never exceed two.
    assign w_credit_ok   = (r_occ == 2'd0) || ((r_occ == 2'd1) && !r_inflight);
    assign w_push        = r_inflight;
    assign w_pop         = (r_occ != 2'd0) && out_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rinc      = 1'b0;
        w_start     = 1'b0;
        w_exit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|req) && !rempty) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                w_rinc = !rempty && w_req_win && w_below_burst && w_credit_ok;
                if (!w_below_burst || !w_req_win || (rempty && !r_inflight)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_inflight && (r_occ == 2'd0)) begin
                    w_exit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rr_ptr     <= '0;
            r_winner     <= '0;
            r_gnt        <= '0;
            r_issued     <= '0;
            r_inflight   <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_inflight   <= w_rinc;
            r_burst_done <= w_exit;
            if (w_start) begin
                r_gnt    <= w_arb_gnt;
                r_winner <= w_arb_idx;
                r_issued <= '0;
            end else if (w_rinc) begin
                r_issued <= r_issued + C_IW'(1);
            end
            if (w_exit) begin
                r_gnt    <= '0;
                r_rr_ptr <= (r_winner == C_PW'(NREQ - 1)) ? '0 : r_winner + C_PW'(1);
            end
        end
    end

    // Skid buffer: r_e0 is the head, r_e1 holds the second word when occ==2.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_occ <= 2'd0;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_e0 <= rdata;
                    end else begin
                        r_e1 <= rdata;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_e0 <= rdata;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rinc       = w_rinc;
    assign out_valid  = (r_occ != 2'd0);
    assign out_data   = r_e0;
    assign out_gnt    = r_gnt;
    assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_sched
// Purpose  : Self-checking bench for fifo_rd_sched with a FIFO model and a
//            word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_sched;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic            rclk;
    logic            rrst_n;
    logic [NREQ-1:0] req;
    logic            rempty;
    logic            rinc;
    logic [DW-1:0]   rdata;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [NREQ-1:0] out_gnt;
    logic            burst_done;

    int total;
    int bad;
    int rinc_cnt;
    int acc_cnt;
    logic seen_done;
    logic [NREQ-1:0] gnt_at_done;
    logic [NREQ-1:0] exp_gnt;

    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] sb_q[$];

    fifo_rd_sched #(
        .NREQ  (NREQ),
        .DW    (DW),
        .BURST (BURST)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .req        (req),
        .rempty     (rempty),
        .rinc       (rinc),
        .rdata      (rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_gnt    (out_gnt),
        .burst_done (burst_done)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample at negedge, model memory read and scoreboard, update at posedge+1.
    task automatic tick();
        logic [DW-1:0] nxt;
        logic [DW-1:0] exp_w;
        nxt = rdata;
        @(negedge rclk);
        seen_done   = burst_done;
        gnt_at_done = out_gnt;
        if (rinc) begin
            rinc_cnt++;
            total++;
            if (rempty !== 1'b0) begin
                bad++;
                $display("FAIL rinc_when_empty: rinc=1 with rempty=%0b, required rempty=0", rempty);
            end else begin
                nxt = mem_q.pop_front();
            end
        end
        if (out_valid && out_ready) begin
            acc_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL extra_word: got data=%0h gnt=%b, required no word", out_data, out_gnt);
            end else begin
                exp_w = sb_q.pop_front();
                if (out_data !== exp_w || out_gnt !== exp_gnt) begin
                    bad++;
                    $display("FAIL word: got data=%0h gnt=%b, required data=%0h gnt=%b",
                             out_data, out_gnt, exp_w, exp_gnt);
                end
            end
        end
        @(posedge rclk);
        #1;
        rdata  = nxt;
        rempty = (mem_q.size() == 0);
    endtask

    task automatic do_reset();
        rrst_n    = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        rdata     = '0;
        rempty    = 1'b1;
        exp_gnt   = '0;
        mem_q.delete();
        sb_q.delete();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n   = 1'b1;
        rinc_cnt = 0;
        acc_cnt  = 0;
    endtask

    task automatic fill(input int n);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = DW'($urandom_range(1, (1 << DW) - 1));
            mem_q.push_back(w);
            sb_q.push_back(w);
        end
        rempty = (mem_q.size() == 0);
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < max_cycles) begin
            tick();
            n++;
        end
        if (!seen_done) begin
            total++;
            bad++;
            $display("FAIL burst_done_timeout: no burst_done within %0d cycles", max_cycles);
        end
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        req = '0; out_ready = 1'b0; rdata = '0; rempty = 1'b1;
        #1;
        total++;
        if ({rinc, out_valid, out_data, out_gnt, burst_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rinc=%0b valid=%0b data=%0h gnt=%b done=%0b, required all 0",
                     rinc, out_valid, out_data, out_gnt, burst_done);
        end
        do_reset();
    endtask

    task automatic test_single_consumer();
        do_reset();
        fill(6);
        req = 4'b0010; out_ready = 1'b1; exp_gnt = 4'b0010;
        wait_done(60);
        total++;
        if (rinc_cnt !== 4 || acc_cnt !== 4) begin
            bad++;
            $display("FAIL single_burst1: rinc=%0d words=%0d, required 4 and 4", rinc_cnt, acc_cnt);
        end
        rinc_cnt = 0; acc_cnt = 0;
        wait_done(60);
        total++;
        if (rinc_cnt !== 2 || acc_cnt !== 2) begin
            bad++;
            $display("FAIL single_burst2: rinc=%0d words=%0d, required 2 and 2", rinc_cnt, acc_cnt);
        end
        total++;
        if (sb_q.size() !== 0 || rempty !== 1'b1) begin
            bad++;
            $display("FAIL single_left: pending=%0d rempty=%0b, required 0 and 1", sb_q.size(), rempty);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        fill(24);
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_gnt  = 4'b0001 << (i % 4);
            rinc_cnt = 0; acc_cnt = 0;
            wait_done(60);
            total++;
            if (rinc_cnt !== 4 || acc_cnt !== 4 || gnt_at_done !== 4'b0000) begin
                bad++;
                $display("FAIL rotation_%0d: rinc=%0d words=%0d gnt_at_done=%b, required 4 4 0000",
                         i, rinc_cnt, acc_cnt, gnt_at_done);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        fill(4);
        req = 4'b0001; out_ready = 1'b1; exp_gnt = 4'b0001;
        n = 0;
        while (acc_cnt < 1 && n < 30) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        rinc_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || sb_q.size() == 0 || out_data !== sb_q[0]) begin
                bad++;
                $display("FAIL stall_hold_%0d: valid=%0b data=%0h, required valid=1 data=%0h",
                         i, out_valid, out_data, (sb_q.size() != 0) ? sb_q[0] : '0);
            end
        end
        total++;
        if (rinc_cnt > 2) begin
            bad++;
            $display("FAIL stall_rinc: %0d rinc during stall, required at most 2", rinc_cnt);
        end
        out_ready = 1'b1;
        wait_done(60);
        total++;
        if (acc_cnt !== 4 || sb_q.size() !== 0) begin
            bad++;
            $display("FAIL stall_delivery: words=%0d pending=%0d, required 4 and 0", acc_cnt, sb_q.size());
        end
    endtask

    task automatic test_short_fifo();
        do_reset();
        fill(2);
        req = 4'b0001; out_ready = 1'b1; exp_gnt = 4'b0001;
        wait_done(60);
        total++;
        if (rinc_cnt !== 2 || acc_cnt !== 2 || gnt_at_done !== 4'b0000) begin
            bad++;
            $display("FAIL short_fifo: rinc=%0d words=%0d gnt_at_done=%b, required 2 2 0000",
                     rinc_cnt, acc_cnt, gnt_at_done);
        end
    endtask

    task automatic test_req_drop();
        int n;
        do_reset();
        fill(4);
        req = 4'b0001; out_ready = 1'b1; exp_gnt = 4'b0001;
        n = 0;
        while (rinc_cnt < 1 && n < 30) begin
            tick();
            n++;
        end
        req = 4'b0000;
        wait_done(60);
        repeat (3) tick();
        total++;
        if (rinc_cnt !== 1 || acc_cnt !== 1 || gnt_at_done !== 4'b0000) begin
            bad++;
            $display("FAIL req_drop: rinc=%0d words=%0d gnt=%b, required 1 1 0000",
                     rinc_cnt, acc_cnt, gnt_at_done);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        do_reset();
        fill(6);
        req = 4'b0100; out_ready = 1'b0; exp_gnt = 4'b0100;
        n = 0;
        while (rinc_cnt < 2 && n < 30) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_gnt !== 4'b0100) begin
            bad++;
            $display("FAIL pre_reset: valid=%0b gnt=%b, required 1 0100", out_valid, out_gnt);
        end
        rrst_n = 1'b0;
        #1;
        total++;
        if ({rinc, out_valid, out_data, out_gnt, burst_done} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: rinc=%0b valid=%0b data=%0h gnt=%b done=%0b, required all 0",
                     rinc, out_valid, out_data, out_gnt, burst_done);
        end
        do_reset();
        fill(4);
        req = 4'b1001; out_ready = 1'b1; exp_gnt = 4'b0001;
        wait_done(60);
        total++;
        if (acc_cnt !== 4) begin
            bad++;
            $display("FAIL post_reset_grant: words=%0d, required 4 under gnt 0001", acc_cnt);
        end
    endtask

    initial begin
        total = 0; bad = 0; rinc_cnt = 0; acc_cnt = 0;
        seen_done = 1'b0; gnt_at_done = '0; exp_gnt = '0;
        test_reset();
        test_single_consumer();
        test_rotation();
        test_backpressure();
        test_short_fifo();
        test_req_drop();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
